mac_kbd_serial: RTL and testbench



---
 rtl/mac_kbd_pkg.sv | 29 ++
 rtl/kbd_phase_timer.sv | 32 +++
 rtl/mac_kbd_serial.sv | 178 +++++++++++++++++
 tb/tb_mac_kbd_serial.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_kbd_pkg.sv
// mac_kbd_pkg: shared types and default timing for the Mac Plus keyboard
// serial endpoint.
//   kbdState_t  : link state (IDLE .. R_HI)
//   *_DEF       : default phase lengths in clk8 ticks, null response byte
//   PH_W / TO_W : phase / timeout counter widths
package mac_kbd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    C_LO,
    C_HI,
    WAIT_REL,
    RSP_WAIT,
    R_LO,
    R_HI
  } kbdState_t;

  localparam int CMD_LO_DEF      = 1440;    // 180 us
  localparam int CMD_HI_DEF      = 1760;    // 220 us
  localparam int RSP_LO_DEF      = 1280;    // 160 us
  localparam int RSP_HI_DEF      = 1360;    // 170 us
  localparam int RSP_TIMEOUT_DEF = 2000000; // 250 ms

  localparam logic [7:0] NULL_BYTE_DEF = 8'h7B;

  localparam int PH_W = 11;
  localparam int TO_W = 21;

endpackage

// File: rtl/kbd_phase_timer.sv
// kbd_phase_timer: loadable down-counter used to time link phases.
//   clk32, _reset : clock, async active-low reset
//   tick          : clk8 enable; the counter only moves on ticks
//   load, loadVal : on a tick, load loadVal (takes priority over counting)
//   done          : count has reached zero
// A phase of N ticks is produced by loading N-1 on the tick that enters
// the phase; done is then seen on the N-th tick spent in it.
module kbd_phase_timer #(
  parameter int W = 11
) (
  input  logic         clk32,
  input  logic         _reset,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk32 or negedge _reset) begin
    if (!_reset) begin
      count <= '0;
    end else if (tick) begin
      if (load)             count <= loadVal;
      else if (count != '0) count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/mac_kbd_serial.sv
// mac_kbd_serial: keyboard-side endpoint of the Mac Plus keyboard link.
// Drives the keyboard clock, shifts in an 8-bit command from the Mac
// (MSB first, sampled on our clock rising edge), then shifts out an
// 8-bit response (MSB first, changed on our clock falling edge).
//   clk32, _reset       : system clock, async active-low reset
//   clk8_en_p           : clk8 enable, all state advances on it
//   kbd_clk_o           : keyboard clock line (1 = high/idle)
//   kbd_data_i          : resolved data line level
//   kbd_data_o          : our data drive (1 = released, wired-AND)
//   cmd_data/cmd_strobe : received command and its one-tick pulse
//   rsp_data/rsp_valid  : response from the key-event source
//   rsp_ack             : one-tick pulse when rsp_data is taken
//   busy                : not IDLE
module mac_kbd_serial
  import mac_kbd_pkg::*;
#(
  parameter int         CMD_LO      = CMD_LO_DEF,
  parameter int         CMD_HI      = CMD_HI_DEF,
  parameter int         RSP_LO      = RSP_LO_DEF,
  parameter int         RSP_HI      = RSP_HI_DEF,
  parameter int         RSP_TIMEOUT = RSP_TIMEOUT_DEF,
  parameter logic [7:0] NULL_BYTE   = NULL_BYTE_DEF
) (
  input  logic       clk32,
  input  logic       _reset,
  input  logic       clk8_en_p,
  output logic       kbd_clk_o,
  input  logic       kbd_data_i,
  output logic       kbd_data_o,
  output logic [7:0] cmd_data,
  output logic       cmd_strobe,
  input  logic [7:0] rsp_data,
  input  logic       rsp_valid,
  output logic       rsp_ack,
  output logic       busy
);

  localparam logic [PH_W-1:0] CMD_LO_N = PH_W'(CMD_LO - 1);
  localparam logic [PH_W-1:0] CMD_HI_N = PH_W'(CMD_HI - 1);
  localparam logic [PH_W-1:0] RSP_LO_N = PH_W'(RSP_LO - 1);
  localparam logic [PH_W-1:0] RSP_HI_N = PH_W'(RSP_HI - 1);
  localparam logic [TO_W-1:0] RSP_TO_N = TO_W'(RSP_TIMEOUT - 1);

  kbdState_t       state;
  logic [3:0]      bitCnt;
  logic [7:0]      shReg;
  logic            phLoad;
  logic [PH_W-1:0] phVal;
  logic            phDone;
  logic            toLoad;
  logic            toDone;
  logic            conflict;
  logic [7:0]      rspByte;

  // Line low while we release it means the Mac is fighting us.
  assign conflict = ((state == R_LO) || (state == R_HI)) && !kbd_data_i && kbd_data_o;
  // rsp_valid wins over a timeout expiring on the same tick.
  assign rspByte  = rsp_valid ? rsp_data : NULL_BYTE;
  assign busy     = (state != IDLE);
  assign toLoad   = (state == WAIT_REL) && kbd_data_i;

  // Phase timer is reloaded on every tick that moves to a new phase; the
  // value is the length of the phase being entered.
  always_comb begin
    phLoad = 1'b0;
    phVal  = '0;
    case (state)
      IDLE:     begin phLoad = !kbd_data_i;          phVal = CMD_LO_N; end
      C_LO:     begin phLoad = phDone;               phVal = CMD_HI_N; end
      C_HI:     begin phLoad = phDone;               phVal = (bitCnt == 4'd8) ? '0 : CMD_LO_N; end
      RSP_WAIT: begin phLoad = rsp_valid || toDone;  phVal = RSP_LO_N; end
      R_LO:     begin phLoad = phDone;               phVal = RSP_HI_N; end
      R_HI:     begin phLoad = phDone;               phVal = (bitCnt == 4'd8) ? '0 : RSP_LO_N; end
      default:  ;
    endcase
  end

  kbd_phase_timer #(.W(PH_W)) phTimer (
    .clk32   (clk32),
    ._reset  (_reset),
    .tick    (clk8_en_p),
    .load    (phLoad),
    .loadVal (phVal),
    .done    (phDone)
  );

  kbd_phase_timer #(.W(TO_W)) toTimer (
    .clk32   (clk32),
    ._reset  (_reset),
    .tick    (clk8_en_p),
    .load    (toLoad),
    .loadVal (RSP_TO_N),
    .done    (toDone)
  );

  always_ff @(posedge clk32 or negedge _reset) begin
    if (!_reset) begin
      state      <= IDLE;
      kbd_clk_o  <= 1'b1;
      kbd_data_o <= 1'b1;
      cmd_data   <= '0;
      cmd_strobe <= 1'b0;
      rsp_ack    <= 1'b0;
      bitCnt     <= '0;
      shReg      <= '0;
    end else begin
      // Pulses last a single clk32 cycle regardless of enable spacing.
      cmd_strobe <= 1'b0;
      rsp_ack    <= 1'b0;
      if (clk8_en_p) begin
        case (state)
          IDLE: if (!kbd_data_i) begin
            bitCnt    <= '0;
            kbd_clk_o <= 1'b0;
            state     <= C_LO;
          end
          C_LO: if (phDone) begin
            // Rising edge of our clock: Mac data is stable here.
            shReg     <= {shReg[6:0], kbd_data_i};
            bitCnt    <= bitCnt + 4'd1;
            kbd_clk_o <= 1'b1;
            state     <= C_HI;
          end
          C_HI: if (phDone) begin
            if (bitCnt == 4'd8) begin
              cmd_data   <= shReg;
              cmd_strobe <= 1'b1;
              state      <= WAIT_REL;
            end else begin
              kbd_clk_o <= 1'b0;
              state     <= C_LO;
            end
          end
          WAIT_REL: if (kbd_data_i) state <= RSP_WAIT;
          RSP_WAIT: if (rsp_valid || toDone) begin
            kbd_data_o <= rspByte[7];
            shReg      <= {rspByte[6:0], 1'b0};
            bitCnt     <= 4'd1;
            rsp_ack    <= rsp_valid;
            kbd_clk_o  <= 1'b0;
            state      <= R_LO;
          end
          R_LO: begin
            if (conflict) begin
              kbd_clk_o  <= 1'b1;
              kbd_data_o <= 1'b1;
              state      <= IDLE;
            end else if (phDone) begin
              kbd_clk_o <= 1'b1;
              state     <= R_HI;
            end
          end
          R_HI: begin
            if (conflict) begin
              kbd_clk_o  <= 1'b1;
              kbd_data_o <= 1'b1;
              state      <= IDLE;
            end else if (phDone) begin
              if (bitCnt == 4'd8) begin
                kbd_data_o <= 1'b1;
                state      <= IDLE;
              end else begin
                // Falling edge of our clock: present the next bit.
                kbd_data_o <= shReg[7];
                shReg      <= {shReg[6:0], 1'b0};
                bitCnt     <= bitCnt + 4'd1;
                kbd_clk_o  <= 1'b0;
                state      <= R_LO;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_kbd_serial.sv
// tb_mac_kbd_serial: directed bench for mac_kbd_serial with a small Mac-side
// line model. Short timing: CMD 4/5, RSP 3/3, timeout 50 ticks.
module tb_mac_kbd_serial;

  localparam int CLO = 4, CHI = 5, RLO = 3, RHI = 3, RTO = 50;

  logic       clk32 = 1'b0;
  logic       rstN;
  logic       en = 1'b0;
  logic       macDrive;
  logic       kbdData;
  logic       kbd_clk_o, kbd_data_o, cmd_strobe, rsp_ack, busy;
  logic [7:0] cmd_data, rsp_data;
  logic       rsp_valid;

  int nChecks = 0, nPass = 0;
  int stbCount = 0, ackCount = 0;

  assign kbdData = macDrive & kbd_data_o;

  mac_kbd_serial #(
    .CMD_LO(CLO), .CMD_HI(CHI), .RSP_LO(RLO), .RSP_HI(RHI),
    .RSP_TIMEOUT(RTO), .NULL_BYTE(8'h7B)
  ) dut (
    .clk32      (clk32),
    ._reset     (rstN),
    .clk8_en_p  (en),
    .kbd_clk_o  (kbd_clk_o),
    .kbd_data_i (kbdData),
    .kbd_data_o (kbd_data_o),
    .cmd_data   (cmd_data),
    .cmd_strobe (cmd_strobe),
    .rsp_data   (rsp_data),
    .rsp_valid  (rsp_valid),
    .rsp_ack    (rsp_ack),
    .busy       (busy)
  );

  initial forever #5 clk32 = ~clk32;
  // Enable every other clk32 cycle so pulse width is distinguishable from
  // enable width.
  initial forever begin @(negedge clk32); en = ~en; end

  always @(negedge clk32) begin
    if (cmd_strobe) stbCount++;
    if (rsp_ack)    ackCount++;
  end

  typedef struct {
    logic [7:0] cmd;
    int         mode;     // 0 no valid, 1 valid at once, 2 valid on timeout tick
    logic [7:0] rsp;
    logic [7:0] expRsp;
    int         expTicks; // strobe observation to first response clock fall
    int         expAck;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string nm, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  task automatic tick();
    @(posedge clk32);
    while (!en) @(posedge clk32);
    #1;
  endtask

  // Mac side of a command: pull data low, present bits while clock is low.
  task automatic sendCmd(input logic [7:0] b, input int nbits, output int errs);
    int n, lo;
    logic [7:0] v;
    v = b;
    errs = 0;
    macDrive = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      n = 0;
      while (kbd_clk_o && n < 100) begin tick(); n++; end
      if (n != ((i == 0) ? 1 : CHI)) errs++;
      macDrive = v[7 - i];
      lo = 0;
      while (!kbd_clk_o && lo < 100) begin tick(); lo++; end
      if (lo != CLO) errs++;
    end
    if (nbits == 8) begin
      n = 0;
      while (!cmd_strobe && n < 100) begin tick(); n++; end
      if (n != CHI) errs++;
    end
  endtask

  // Mac side of a response: sample the line on each clock rising edge.
  task automatic recvRsp(output logic [7:0] got, output int errs);
    int n, lo;
    errs = 0;
    got  = '0;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      while (kbd_clk_o && n < 100) begin tick(); n++; end
      if (n >= 100 || (i > 0 && n != RHI)) errs++;
      lo = 0;
      while (!kbd_clk_o && lo < 100) begin tick(); lo++; end
      if (lo != RLO) errs++;
      got = {got[6:0], kbdData};
    end
    n = 0;
    while (busy && n < 100) begin tick(); n++; end
    if (n != RHI) errs++;
  endtask

  task automatic doRsp(input int mode, input logic [7:0] rsp, input logic [7:0] expRsp,
                       input int expTicks, input int expAck, input string nm);
    int n, a0, errs;
    logic [7:0] got;
    logic [7:0] e;
    e = expRsp;
    a0 = ackCount;
    macDrive = 1'b1;
    rsp_data = rsp;
    n = 0;
    while (kbd_clk_o && n < 200) begin
      if (mode == 1 && n == 0)  rsp_valid = 1'b1;
      if (mode == 2 && n == RTO) rsp_valid = 1'b1;
      tick();
      n++;
    end
    check({nm, " ticks to first rsp clock"}, n, expTicks);
    check({nm, " rsp_ack level"}, int'(rsp_ack), expAck);
    check({nm, " first bit with ack"}, int'(kbd_data_o), int'(e[7]));
    rsp_valid = 1'b0;
    recvRsp(got, errs);
    check({nm, " response byte"}, int'(got), int'(expRsp));
    check({nm, " response timing errors"}, errs, 0);
    check({nm, " rsp_ack pulses"}, ackCount - a0, expAck);
    check({nm, " busy after rsp"}, int'(busy), 0);
    check({nm, " data released after rsp"}, int'(kbd_data_o), 1);
  endtask

  initial begin
    int errs, n, s0, a0, rises;
    logic prevClk;

    vecs[0] = '{cmd: 8'h10, mode: 1, rsp: 8'hA5, expRsp: 8'hA5, expTicks: 2,       expAck: 1};
    vecs[1] = '{cmd: 8'h14, mode: 0, rsp: 8'hA5, expRsp: 8'h7B, expTicks: RTO + 1, expAck: 0};
    vecs[2] = '{cmd: 8'h36, mode: 2, rsp: 8'h3C, expRsp: 8'h3C, expTicks: RTO + 1, expAck: 1};
    vecs[3] = '{cmd: 8'hC2, mode: 1, rsp: 8'h00, expRsp: 8'h00, expTicks: 2,       expAck: 1};

    rstN = 1'b0; macDrive = 1'b1; rsp_valid = 1'b0; rsp_data = '0;
    #23;
    check("reset kbd_clk_o",  int'(kbd_clk_o), 1);
    check("reset kbd_data_o", int'(kbd_data_o), 1);
    check("reset cmd_data",   int'(cmd_data), 0);
    check("reset cmd_strobe", int'(cmd_strobe), 0);
    check("reset rsp_ack",    int'(rsp_ack), 0);
    check("reset busy",       int'(busy), 0);
    rstN = 1'b1;
    repeat (3) tick();
    check("idle busy", int'(busy), 0);

    for (int v = 0; v < 4; v++) begin
      s0 = stbCount;
      sendCmd(vecs[v].cmd, 8, errs);
      check($sformatf("vec%0d command timing errors", v), errs, 0);
      check($sformatf("vec%0d cmd_data", v), int'(cmd_data), int'(vecs[v].cmd));
      doRsp(vecs[v].mode, vecs[v].rsp, vecs[v].expRsp, vecs[v].expTicks, vecs[v].expAck,
            $sformatf("vec%0d", v));
      check($sformatf("vec%0d cmd_strobe pulses", v), stbCount - s0, 1);
    end

    // Reset during bit 4 clock-low, after bits 7..4 were taken.
    sendCmd(8'h16, 4, errs);
    check("partial command timing errors", errs, 0);
    n = 0;
    while (kbd_clk_o && n < 20) begin tick(); n++; end
    check("partial reached clock low", int'(kbd_clk_o), 0);
    s0 = stbCount;
    macDrive = 1'b1;
    rstN = 1'b0;
    #1;
    check("midreset kbd_clk_o",  int'(kbd_clk_o), 1);
    check("midreset busy",       int'(busy), 0);
    check("midreset cmd_data",   int'(cmd_data), 0);
    check("midreset kbd_data_o", int'(kbd_data_o), 1);
    #20;
    rstN = 1'b1;
    repeat (3) tick();
    check("midreset no strobe", stbCount - s0, 0);
    sendCmd(8'h16, 8, errs);
    check("after reset command timing errors", errs, 0);
    check("after reset cmd_data", int'(cmd_data), 8'h16);
    doRsp(1, 8'h5A, 8'h5A, 2, 1, "after reset");

    // Conflict: Mac pulls data low during R_HI of response bit 2.
    sendCmd(8'h2A, 8, errs);
    check("conflict command timing errors", errs, 0);
    check("conflict cmd_data", int'(cmd_data), 8'h2A);
    macDrive = 1'b1; rsp_data = 8'hFF; rsp_valid = 1'b1;
    a0 = ackCount;
    tick();
    s0 = stbCount;
    n = 0;
    while (!rsp_ack && n < 20) begin tick(); n++; end
    rsp_valid = 1'b0;
    rises = 0; prevClk = kbd_clk_o; n = 0;
    while (rises < 3 && n < 200) begin
      tick();
      if (!prevClk && kbd_clk_o) rises++;
      prevClk = kbd_clk_o;
      n++;
    end
    check("conflict reached bit 2 high", rises, 3);
    macDrive = 1'b0;
    tick();
    check("conflict busy",       int'(busy), 0);
    check("conflict kbd_data_o", int'(kbd_data_o), 1);
    check("conflict kbd_clk_o",  int'(kbd_clk_o), 1);
    macDrive = 1'b1;
    tick(); tick();
    check("conflict stays idle", int'(busy), 0);
    check("conflict rsp_ack pulses", ackCount - a0, 1);
    check("conflict no cmd_strobe", stbCount - s0, 0);
    sendCmd(8'h0F, 8, errs);
    check("post conflict command timing errors", errs, 0);
    check("post conflict cmd_data", int'(cmd_data), 8'h0F);
    doRsp(1, 8'h42, 8'h42, 2, 1, "post conflict");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
